// File: rtl/mtimer_pkg.sv
// mtimer_pkg: register map offsets, reset constants and types for the machine timer
package mtimer_pkg;
  typedef logic [63:0] mtime_t;
  localparam int unsigned MTIME_LO_OFS    = 'h00;
  localparam int unsigned MTIME_HI_OFS    = 'h04;
  localparam int unsigned MTIMECMP_BASE   = 'h10;
  localparam int unsigned MTIMECMP_STRIDE = 8;
  localparam mtime_t      MTIMECMP_RST    = '1;
endpackage

// File: rtl/mtime_tick_gen.sv
// mtime_tick_gen: prescaler producing a one-cycle TICK enable every PRESCALE enabled cycles
// Ports: CLK clock, RSTn sync active-low reset, EN count enable, TICK enable pulse (combinational on the wrap count)
module mtime_tick_gen #(
  parameter int PRESCALE = 1
) (
  input  logic CLK,
  input  logic RSTn,
  input  logic EN,
  output logic TICK
);
  localparam int CW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
  logic [CW-1:0] cnt;
  assign TICK = EN && cnt == CW'(PRESCALE - 1);
  always_ff @(posedge CLK) begin
    if (!RSTn) cnt <= '0;
    else if (EN) cnt <= TICK ? '0 : cnt + CW'(1);
  end
endmodule

// File: rtl/mtimer_clint.sv
// mtimer_clint: memory-mapped RISC-V machine timer with per-hart mtimecmp and MTIP
// Ports: CLK/RSTn (sync active-low), EN count enable, BUS_* 32-bit single-cycle-latency
//        register bus (ACK one cycle after REQ, ERR on unmapped offsets), MTIME_VALUE live
//        counter, MTIP registered per-hart interrupt level
module mtimer_clint
  import mtimer_pkg::*;
#(
  parameter int PRESCALE = 1,
  parameter int N_HARTS  = 1,
  parameter int ADDR_W   = 8
) (
  input  logic               CLK,
  input  logic               RSTn,
  input  logic               EN,
  input  logic               BUS_REQ,
  input  logic               BUS_WE,
  input  logic [ADDR_W-1:0]  BUS_ADDR,
  input  logic [31:0]        BUS_WDATA,
  output logic [31:0]        BUS_RDATA,
  output logic               BUS_ACK,
  output logic               BUS_ERR,
  output mtime_t             MTIME_VALUE,
  output logic [N_HARTS-1:0] MTIP
);
  logic tick;
  mtime_t mtime;
  mtime_t cmp [N_HARTS];
  logic [31:0] shadow;
  logic [ADDR_W-1:0] ofs;
  logic [N_HARTS-1:0] lo_hit, hi_hit;
  logic mt_lo_hit, mt_hi_hit, mapped, wr, mt_lo_wr, mt_hi_wr;
  logic [31:0] rd_mux;
  logic unused_addr_lsb;
  mtime_tick_gen #(.PRESCALE(PRESCALE)) u_tick (
    .CLK (CLK),
    .RSTn(RSTn),
    .EN  (EN),
    .TICK(tick)
  );
  assign unused_addr_lsb = ^BUS_ADDR[1:0];
  assign ofs = {BUS_ADDR[ADDR_W-1:2], 2'b00};
  assign wr = BUS_REQ && BUS_WE;
  assign mt_lo_hit = ofs == ADDR_W'(MTIME_LO_OFS);
  assign mt_hi_hit = ofs == ADDR_W'(MTIME_HI_OFS);
  assign mt_lo_wr = wr && mt_lo_hit;
  assign mt_hi_wr = wr && mt_hi_hit;
  assign MTIME_VALUE = mtime;
  // MTIME_HI reads come from the shadow latched by the last MTIME_LO read, so a LO-then-HI
  // pair always sees one coherent 64-bit snapshot even across a carry.
  always_comb begin
    lo_hit = '0;
    hi_hit = '0;
    rd_mux = mt_lo_hit ? mtime[31:0] : mt_hi_hit ? shadow : '0;
    for (int h = 0; h < N_HARTS; h++) begin
      lo_hit[h] = ofs == ADDR_W'(MTIMECMP_BASE + MTIMECMP_STRIDE * h);
      hi_hit[h] = ofs == ADDR_W'(MTIMECMP_BASE + MTIMECMP_STRIDE * h + 4);
      if (lo_hit[h]) rd_mux = cmp[h][31:0];
      if (hi_hit[h]) rd_mux = cmp[h][63:32];
    end
    mapped = mt_lo_hit || mt_hi_hit || |lo_hit || |hi_hit;
  end
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      mtime     <= '0;
      shadow    <= '0;
      cmp       <= '{default: MTIMECMP_RST};
      MTIP      <= '0;
      BUS_ACK   <= 1'b0;
      BUS_ERR   <= 1'b0;
      BUS_RDATA <= '0;
    end else begin
      BUS_ACK   <= BUS_REQ;
      BUS_ERR   <= BUS_REQ && !mapped;
      BUS_RDATA <= BUS_REQ && !BUS_WE ? rd_mux : '0;
      if (BUS_REQ && !BUS_WE && mt_lo_hit) shadow <= mtime[63:32];
      // A software write to either half wins over the tick on that edge; the tick is dropped.
      mtime <= mt_lo_wr || mt_hi_wr
             ? {mt_hi_wr ? BUS_WDATA : mtime[63:32], mt_lo_wr ? BUS_WDATA : mtime[31:0]}
             : mtime + 64'(tick);
      for (int h = 0; h < N_HARTS; h++) begin
        if (wr && lo_hit[h]) cmp[h][31:0] <= BUS_WDATA;
        if (wr && hi_hit[h]) cmp[h][63:32] <= BUS_WDATA;
        MTIP[h] <= mtime >= cmp[h];
      end
    end
  end
endmodule

// File: tb/tb_mtimer_clint.sv
// tb_mtimer_clint: scoreboard bench for mtimer_clint (bus responses queued, monitor pops on ACK)
module tb_mtimer_clint;
  import mtimer_pkg::*;
  logic CLK = 1'b0;
  always #5 CLK = ~CLK;
  logic RSTn, EN, BUS_REQ, BUS_WE, BUS_ACK, BUS_ERR;
  logic [7:0] BUS_ADDR;
  logic [31:0] BUS_WDATA, BUS_RDATA;
  mtime_t MTIME_VALUE;
  logic [1:0] MTIP;
  logic rst4_n, en4, ack4, err4;
  logic [31:0] rdata4;
  mtime_t mtime4;
  logic [0:0] mtip4;
  typedef struct {
    string name;
    logic err;
    logic [31:0] rdata;
  } exp_t;
  exp_t sb[$];
  int n_tests = 0;
  int n_fail = 0;
  mtimer_clint #(.PRESCALE(1), .N_HARTS(2), .ADDR_W(8)) dut (
    .CLK(CLK), .RSTn(RSTn), .EN(EN), .BUS_REQ(BUS_REQ), .BUS_WE(BUS_WE),
    .BUS_ADDR(BUS_ADDR), .BUS_WDATA(BUS_WDATA), .BUS_RDATA(BUS_RDATA),
    .BUS_ACK(BUS_ACK), .BUS_ERR(BUS_ERR), .MTIME_VALUE(MTIME_VALUE), .MTIP(MTIP)
  );
  mtimer_clint #(.PRESCALE(4), .N_HARTS(1), .ADDR_W(8)) dut4 (
    .CLK(CLK), .RSTn(rst4_n), .EN(en4), .BUS_REQ(1'b0), .BUS_WE(1'b0),
    .BUS_ADDR(8'h00), .BUS_WDATA(32'h0), .BUS_RDATA(rdata4),
    .BUS_ACK(ack4), .BUS_ERR(err4), .MTIME_VALUE(mtime4), .MTIP(mtip4)
  );
  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic step();
    @(posedge CLK);
    #1;
  endtask
  task automatic bus(string name, logic we, logic [7:0] a, logic [31:0] wd, logic e, logic [31:0] rd);
    BUS_REQ = 1'b1;
    BUS_WE = we;
    BUS_ADDR = a;
    BUS_WDATA = wd;
    step();
    sb.push_back('{name, e, rd});
    BUS_REQ = 1'b0;
  endtask
  task automatic monitor();
    exp_t x;
    forever begin
      @(negedge CLK);
      if (BUS_ACK === 1'b1) begin
        n_tests++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_ack: ack=1 err=%b rdata=%h, no access outstanding", BUS_ERR, BUS_RDATA);
        end else begin
          x = sb.pop_front();
          if (BUS_ERR !== x.err || BUS_RDATA !== x.rdata) begin
            n_fail++;
            $display("FAIL %s: err=%b rdata=%h expected err=%b rdata=%h", x.name, BUS_ERR, BUS_RDATA, x.err, x.rdata);
          end
        end
      end else if (sb.size() != 0) begin
        x = sb.pop_front();
        n_tests++;
        n_fail++;
        $display("FAIL %s: ack=%b expected 1", x.name, BUS_ACK);
      end else if (BUS_RDATA !== 32'h0 || BUS_ERR !== 1'b0) begin
        n_tests++;
        n_fail++;
        $display("FAIL idle_bus: rdata=%h err=%b expected 0/0", BUS_RDATA, BUS_ERR);
      end
    end
  endtask
  initial begin
    RSTn = 1'b0; EN = 1'b0; BUS_REQ = 1'b0; BUS_WE = 1'b0; BUS_ADDR = '0; BUS_WDATA = '0;
    rst4_n = 1'b0; en4 = 1'b0;
    fork monitor(); join_none
    step(); step();
    chk("rst_mtime", MTIME_VALUE, 64'h0);
    chk("rst_mtip", MTIP, 2'b00);
    chk("rst_ack", BUS_ACK, 1'b0);
    RSTn = 1'b1;
    EN = 1'b1;
    repeat (10) step();
    EN = 1'b0;
    chk("t1_mtime10", MTIME_VALUE, 64'd10);
    chk("t1_mtip", MTIP, 2'b00);
    bus("t1_cmp0_lo", 1'b0, 8'h10, 32'h0, 1'b0, 32'hFFFF_FFFF);
    bus("t1_cmp0_hi", 1'b0, 8'h14, 32'h0, 1'b0, 32'hFFFF_FFFF);
    bus("t1_cmp1_lo", 1'b0, 8'h18, 32'h0, 1'b0, 32'hFFFF_FFFF);
    bus("t1_cmp1_hi", 1'b0, 8'h1C, 32'h0, 1'b0, 32'hFFFF_FFFF);
    bus("t3_wr_lo", 1'b1, 8'h00, 32'hFFFF_FFFF, 1'b0, 32'h0);
    bus("t3_wr_hi", 1'b1, 8'h04, 32'h0, 1'b0, 32'h0);
    EN = 1'b1;
    step();
    EN = 1'b0;
    chk("t3_carry", MTIME_VALUE, 64'h1_0000_0000);
    bus("t3_rd_lo", 1'b0, 8'h00, 32'h0, 1'b0, 32'h0);
    bus("t3_rd_hi", 1'b0, 8'h04, 32'h0, 1'b0, 32'h1);
    bus("t4_wr_lo", 1'b1, 8'h00, 32'h0, 1'b0, 32'h0);
    bus("t4_wr_hi", 1'b1, 8'h04, 32'h0, 1'b0, 32'h0);
    bus("t4_cmp_lo", 1'b1, 8'h10, 32'd20, 1'b0, 32'h0);
    bus("t4_cmp_hi", 1'b1, 8'h14, 32'h0, 1'b0, 32'h0);
    chk("t4_mtip_pre", MTIP, 2'b00);
    EN = 1'b1;
    for (int k = 1; k <= 22; k++) begin
      step();
      chk("t4_mtime", MTIME_VALUE, 64'(k));
      chk("t4_mtip", MTIP, k >= 21 ? 2'b01 : 2'b00);
    end
    EN = 1'b0;
    bus("t4_raise_cmp", 1'b1, 8'h10, 32'd100, 1'b0, 32'h0);
    chk("t4_mtip_lag", MTIP, 2'b01);
    step();
    chk("t4_mtip_fall", MTIP, 2'b00);
    bus("t5_wr_hi", 1'b1, 8'h04, 32'hFFFF_FFFF, 1'b0, 32'h0);
    bus("t5_wr_lo", 1'b1, 8'h00, 32'hFFFF_FFFE, 1'b0, 32'h0);
    EN = 1'b1;
    step();
    chk("t5_max", MTIME_VALUE, 64'hFFFF_FFFF_FFFF_FFFF);
    step();
    EN = 1'b0;
    chk("t5_wrap", MTIME_VALUE, 64'h0);
    chk("t5_mtip_max", MTIP, 2'b11);
    step();
    chk("t5_mtip_wrapped", MTIP, 2'b00);
    bus("t6_rd_08", 1'b0, 8'h08, 32'h0, 1'b1, 32'h0);
    bus("t6_wr_0c", 1'b1, 8'h0C, 32'hDEAD_BEEF, 1'b1, 32'h0);
    bus("t6_rd_20", 1'b0, 8'h20, 32'h0, 1'b1, 32'h0);
    bus("t6_cmp1_hi", 1'b0, 8'h1C, 32'h0, 1'b0, 32'hFFFF_FFFF);
    EN = 1'b1;
    bus("t6_lo_on_tick", 1'b1, 8'h00, 32'h1234, 1'b0, 32'h0);
    EN = 1'b0;
    chk("t6_lo_no_inc", MTIME_VALUE, 64'h1234);
    EN = 1'b1;
    bus("t6_hi_on_tick", 1'b1, 8'h04, 32'h5, 1'b0, 32'h0);
    EN = 1'b0;
    chk("t6_hi_no_inc", MTIME_VALUE, 64'h5_0000_1234);
    bus("t6_wr_hi0", 1'b1, 8'h04, 32'h0, 1'b0, 32'h0);
    bus("t6_wr_loff", 1'b1, 8'h00, 32'hFFFF_FFFF, 1'b0, 32'h0);
    EN = 1'b1;
    bus("t6_atomic_lo", 1'b0, 8'h00, 32'h0, 1'b0, 32'hFFFF_FFFF);
    EN = 1'b0;
    chk("t6_atomic_mtime", MTIME_VALUE, 64'h1_0000_0000);
    bus("t6_atomic_hi", 1'b0, 8'h04, 32'h0, 1'b0, 32'h0);
    bus("t6_rd_lo2", 1'b0, 8'h00, 32'h0, 1'b0, 32'h0);
    bus("t6_rd_hi_lsb", 1'b0, 8'h07, 32'h0, 1'b0, 32'h1);
    BUS_REQ = 1'b1; BUS_WE = 1'b0; BUS_ADDR = 8'h00; RSTn = 1'b0;
    step();
    BUS_REQ = 1'b0;
    chk("t6_rst_no_ack", BUS_ACK, 1'b0);
    RSTn = 1'b1;
    step();
    chk("t6_rst_mtime", MTIME_VALUE, 64'h0);
    chk("t6_rst_mtip", MTIP, 2'b00);
    bus("t6_rst_cmp0_lo", 1'b0, 8'h10, 32'h0, 1'b0, 32'hFFFF_FFFF);
    bus("t6_rst_cmp0_hi", 1'b0, 8'h14, 32'h0, 1'b0, 32'hFFFF_FFFF);
    step();
    rst4_n = 1'b1;
    en4 = 1'b1;
    repeat (3) step();
    chk("t2_pre_tick", mtime4, 64'd0);
    step();
    chk("t2_first_tick", mtime4, 64'd1);
    repeat (12) step();
    chk("t2_after16", mtime4, 64'd4);
    en4 = 1'b0;
    repeat (8) step();
    chk("t2_hold", mtime4, 64'd4);
    en4 = 1'b1;
    repeat (3) step();
    chk("t2_resume_wait", mtime4, 64'd4);
    step();
    chk("t2_resume_tick", mtime4, 64'd5);
    repeat (3) step();
    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
